// File: rtl/lab6_pkg.sv
// rtl/lab6_pkg.sv - shared constants for the lab6 universal shift register
package lab6_pkg;

   // Width of the shift register
   localparam int USR_W = 8;

   // Bit positions inside the control nibble
   localparam int SI_BIT  = 0;
   localparam int SH_BIT  = 1;
   localparam int SHL_BIT = 2;
   localparam int LD_BIT  = 3;

endpackage

// File: rtl/usr_bit_cell.sv
// rtl/usr_bit_cell.sv - next-state selector for one shift register bit
module usr_bit_cell (
   input  logic d_i,
   input  logic prev_i,
   input  logic left_i,
   input  logic right_i,
   input  logic ld_i,
   input  logic sh_i,
   input  logic shl_i,
   output logic nxt_o
);

   // Load beats shift; a left shift pulls from the lower (right) neighbour,
   // a right shift pulls from the higher (left) neighbour; otherwise hold.
   always_comb begin
      nxt_o = prev_i;
      if (ld_i) begin
         nxt_o = d_i;
      end else if (sh_i) begin
         nxt_o = shl_i ? right_i : left_i;
      end
   end

endmodule

// File: rtl/lab6_usr.sv
// rtl/lab6_usr.sv - 8-bit universal shift register with load, shift and hold
module lab6_usr
   import lab6_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   output logic [USR_W-1:0] out,
   input  logic [USR_W-1:0] prev,
   input  logic [3:0]       in1,
   input  logic [3:0]       in2,
   input  logic [3:0]       in3
);

   logic [USR_W-1:0] load_d;
   logic [USR_W-1:0] out_d;
   logic [USR_W-1:0] out_q;
   logic             si;
   logic             sh;
   logic             shl;
   logic             ld;

   assign load_d = {in2, in1};
   assign si     = in3[SI_BIT];
   assign sh     = in3[SH_BIT];
   assign shl    = in3[SHL_BIT];
   assign ld     = in3[LD_BIT];

   // One selector per bit; edge cells see SI where a neighbour is missing
   for (genvar i = 0; i < USR_W; i++) begin : g_cell
      logic left_nb;
      logic right_nb;

      if (i == USR_W - 1) begin : g_msb
         assign left_nb = si;
      end else begin : g_mid_l
         assign left_nb = prev[i+1];
      end

      if (i == 0) begin : g_lsb
         assign right_nb = si;
      end else begin : g_mid_r
         assign right_nb = prev[i-1];
      end

      usr_bit_cell u_cell (
         .d_i     (load_d[i]),
         .prev_i  (prev[i]),
         .left_i  (left_nb),
         .right_i (right_nb),
         .ld_i    (ld),
         .sh_i    (sh),
         .shl_i   (shl),
         .nxt_o   (out_d[i])
      );
   end

   // State register with synchronous clear taking priority over every operation
   always_ff @(posedge clock) begin
      if (reset) begin
         out_q <= '0;
      end else begin
         out_q <= out_d;
      end
   end

   assign out = out_q;

endmodule

// File: tb/tb_lab6_usr.sv
// tb/tb_lab6_usr.sv - self-checking bench for lab6_usr
module tb_lab6_usr;

   logic       clock;
   logic       reset;
   logic [7:0] out;
   logic [7:0] prev;
   logic [3:0] in1;
   logic [3:0] in2;
   logic [3:0] in3;

   int checks;
   int errors;

   logic [7:0] model_q;
   logic [7:0] sb[$];
   logic [7:0] exp;

   assign prev = out;

   lab6_usr dut (
      .clock (clock),
      .reset (reset),
      .out   (out),
      .prev  (prev),
      .in1   (in1),
      .in2   (in2),
      .in3   (in3)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Behavioural reference built from the priority rules
   function automatic logic [7:0] ref_next(input logic rst, input logic [7:0] p,
                                           input logic [7:0] d, input logic [3:0] c);
      logic [7:0] r;
      if (rst)            r = 8'h00;
      else if (c[3])      r = d;
      else if (c[1] && c[2]) begin
         r = p << 1;
         r[0] = c[0];
      end else if (c[1]) begin
         r = p >> 1;
         r[7] = c[0];
      end else            r = p;
      return r;
   endfunction

   // Drive one operation at the falling edge, queue the model result, settle after the rising edge
   task automatic drive_cycle(input logic rst, input logic [7:0] d, input logic [3:0] c);
      @(negedge clock);
      reset = rst;
      in2   = d[7:4];
      in1   = d[3:0];
      in3   = c;
      model_q = ref_next(rst, model_q, d, c);
      sb.push_back(model_q);
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset;
      drive_cycle(1'b1, 8'($urandom), 4'($urandom));
      exp = sb.pop_front();
      checks++;
      if (out !== 8'h00 || out !== exp) begin
         errors++;
         $display("FAIL reset: out=%h expected=%h", out, 8'h00);
      end
      drive_cycle(1'b0, 8'hFF, 4'b1000);
      exp = sb.pop_front();
      checks++;
      if (out !== exp) begin
         errors++;
         $display("FAIL reset_preload: out=%h expected=%h", out, exp);
      end
      drive_cycle(1'b1, 8'h5A, 4'b1000);
      exp = sb.pop_front();
      checks++;
      if (out !== 8'h00 || out !== exp) begin
         errors++;
         $display("FAIL reset_with_load: out=%h expected=%h", out, 8'h00);
      end
   endtask

   task automatic test_load;
      drive_cycle(1'b0, {4'b0101, 4'b0011}, 4'b1000);
      exp = sb.pop_front();
      checks++;
      if (out !== 8'b01010011 || out !== exp) begin
         errors++;
         $display("FAIL load: out=%h expected=%h", out, 8'b01010011);
      end
   endtask

   task automatic test_shift_right;
      for (int i = 0; i < 5; i++) begin
         drive_cycle(1'b0, 8'h00, 4'b0010);
         exp = sb.pop_front();
         checks++;
         if (out !== exp) begin
            errors++;
            $display("FAIL shr_si0 step %0d: out=%h expected=%h", i, out, exp);
         end
      end
      checks++;
      if (out !== 8'b00000010) begin
         errors++;
         $display("FAIL shr_si0_final: out=%h expected=%h", out, 8'b00000010);
      end
   endtask

   task automatic test_shift_right_si;
      for (int i = 0; i < 10; i++) begin
         drive_cycle(1'b0, 8'h00, 4'b0011);
         exp = sb.pop_front();
         checks++;
         if (out !== exp) begin
            errors++;
            $display("FAIL shr_si1 step %0d: out=%h expected=%h", i, out, exp);
         end
      end
      checks++;
      if (out !== 8'hFF) begin
         errors++;
         $display("FAIL shr_si1_final: out=%h expected=%h", out, 8'hFF);
      end
   endtask

   task automatic test_hold_and_left;
      for (int i = 0; i < 20; i++) begin
         drive_cycle(1'b0, 8'($urandom), 4'b0100);
         exp = sb.pop_front();
         checks++;
         if (out !== 8'hFF || out !== exp) begin
            errors++;
            $display("FAIL hold step %0d: out=%h expected=%h", i, out, 8'hFF);
         end
      end
      drive_cycle(1'b0, 8'h00, 4'b0110);
      exp = sb.pop_front();
      checks++;
      if (out !== 8'hFE || out !== exp) begin
         errors++;
         $display("FAIL shl_si0: out=%h expected=%h", out, 8'hFE);
      end
      drive_cycle(1'b0, 8'h80, 4'b1000);
      exp = sb.pop_front();
      checks++;
      if (out !== exp) begin
         errors++;
         $display("FAIL load_80: out=%h expected=%h", out, exp);
      end
      drive_cycle(1'b0, 8'h00, 4'b0111);
      exp = sb.pop_front();
      checks++;
      if (out !== 8'h01 || out !== exp) begin
         errors++;
         $display("FAIL shl_si1: out=%h expected=%h", out, 8'h01);
      end
   endtask

   task automatic test_priority;
      drive_cycle(1'b0, 8'hA5, 4'b1110);
      exp = sb.pop_front();
      checks++;
      if (out !== 8'hA5 || out !== exp) begin
         errors++;
         $display("FAIL load_beats_shift: out=%h expected=%h", out, 8'hA5);
      end
      drive_cycle(1'b0, 8'h00, 4'b0111);
      exp = sb.pop_front();
      checks++;
      if (out !== 8'h4B || out !== exp) begin
         errors++;
         $display("FAIL shl_midseq: out=%h expected=%h", out, 8'h4B);
      end
      drive_cycle(1'b1, 8'h3C, 4'b1110);
      exp = sb.pop_front();
      checks++;
      if (out !== 8'h00 || out !== exp) begin
         errors++;
         $display("FAIL reset_midseq: out=%h expected=%h", out, 8'h00);
      end
      drive_cycle(1'b0, 8'h00, 4'b0011);
      exp = sb.pop_front();
      checks++;
      if (out !== 8'h80 || out !== exp) begin
         errors++;
         $display("FAIL after_reset_shr: out=%h expected=%h", out, 8'h80);
      end
   endtask

   task automatic test_back_to_back;
      for (int i = 0; i < 60; i++) begin
         drive_cycle(($urandom_range(0, 15) == 0), 8'($urandom), 4'($urandom));
         exp = sb.pop_front();
         checks++;
         if (out !== exp) begin
            errors++;
            $display("FAIL random step %0d: out=%h expected=%h", i, out, exp);
         end
      end
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      model_q = 8'h00;
      reset   = 1'b1;
      in1     = 4'h0;
      in2     = 4'h0;
      in3     = 4'h0;

      test_reset();
      test_load();
      test_shift_right();
      test_shift_right_si();
      test_hold_and_left();
      test_priority();
      test_back_to_back();

      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: left=%0d expected=0", sb.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
